// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-add per clock, LSB first, result published on a done pulse.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Sized to hold N so the final increment never wraps.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_sh, b_sh, res_sh, res_in;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           sbit, cnxt, last;
`ifdef SERIAL_ADD_OVF_EN
    logic           c_msb;
`endif

    assign sbit = a_sh[0] ^ b_sh[0] ^ carry;
    assign cnxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last = (cnt == CW'(N - 1));
    assign busy = (state != IDLE);

    // Sum bits enter at the MSB so after N shifts bit 0 lands at index 0.
    generate
        if (N == 1) begin : g_res1
            assign res_in = sbit;
        end else begin : g_resn
            assign res_in = {sbit, res_sh[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            c_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_in;
                    carry  <= cnxt;
                    cnt    <= cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
                    // Carry entering the sign bit, needed for two's-complement overflow.
                    if (last) c_msb <= carry;
`endif
                end
                DONE: begin
                    sum  <= res_sh;
                    cout <= carry;
                    done <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    ovf  <= c_msb ^ carry;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table at N=8, plus ignore-start, mid-op reset,
// back-to-back and N=1 sequences.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start1, a1, b1, cin1;
    logic       busy1, done1, cout1, ovf1, sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One operation on the N=8 instance; operands are scrambled right after capture.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, output int lat);
        logic [7:0] prev;
        logic       moved;
        @(negedge clk);
        prev  = sum;
        a     = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        check({tag, " busy"}, busy, 1);
        lat   = -1;
        moved = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (sum !== prev) moved = 1'b1;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " sum_hold"}, moved, 0);
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] sum;
        logic       cout, ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, pulses, cyc;
        int dt[3];
        int nd;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #3;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset ovf", ovf, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].cin, lat);
            check($sformatf("vec%0d sum", v), sum, vecs[v].sum);
            check($sformatf("vec%0d cout", v), cout, vecs[v].cout);
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("vec%0d ovf", v), ovf, vecs[v].ovf);
`endif
            check($sformatf("vec%0d busy_at_done", v), busy, 0);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", v), done, 0);
        end

        // start held high with a=FF through ADD must not disturb the running add
        @(negedge clk);
        a = 8'h35; b = 8'h4A; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 8'hFF;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                pulses++;
                start = 1'b0;
                check("ignore sum", sum, 8'h80);
                check("ignore cout", cout, 0);
            end
            @(negedge clk);
        end
        check("ignore pulses", pulses, 1);

        // reset during the 4th ADD cycle aborts with no done
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no_done", pulses, 0);
        run_op("post_reset", 8'h10, 8'h20, 1'b0, lat);
        check("post_reset sum", sum, 8'h30);
        check("post_reset cout", cout, 0);

        // back-to-back with start held
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        nd = 0;
        cyc = 0;
        for (int i = 1; i <= 40 && nd < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dt[nd] = i;
                nd++;
                check($sformatf("b2b sum%0d", nd), sum, 8'h02);
            end
        end
        start = 1'b0;
        check("b2b count", nd, 3);
        if (nd == 3) begin
            check("b2b gap1", dt[1] - dt[0], 10);
            check("b2b gap2", dt[2] - dt[1], 10);
        end
        repeat (12) @(negedge clk);

        // single-bit instance
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done1) begin
                lat = i;
                break;
            end
        end
        check("n1 latency", lat, 2);
        check("n1 sum", sum1, 1);
        check("n1 cout", cout1, 1);
`ifdef SERIAL_ADD_OVF_EN
        check("n1 ovf", ovf1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (N >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port: a  input  N  operand A, captured on accepted start.
REQ-006 SHALL have port: b  input  N  operand B, captured on accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high in ADD and DONE states.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum  output  N  registered sum, A+B+cin mod 2^N.
REQ-011 SHALL have port: cout  output  1  registered carry-out of bit N-1.
REQ-012 SHALL have port (only with SERIAL_ADD_OVF_EN): ovf  output  1  signed two's-complement overflow.

Function
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 IDLE + start=1 SHALL load A/B shift registers from a/b, carry register from cin, bit counter to 0, and go to ADD; start=0 stays in IDLE.
REQ-015 Each ADD cycle SHALL full-add A_sh[0], B_sh[0], carry: sum bit = XOR of the three, next carry = majority of the three.
REQ-016 Each ADD cycle SHALL shift A_sh and B_sh right by one, shift the sum bit into the MSB of the result shift register, update carry, and increment counter.
REQ-017 ADD SHALL last exactly N cycles; on the Nth cycle the FSM SHALL go to DONE.
REQ-018 In DONE, the result register SHALL be copied to sum, carry to cout, done SHALL be 1 for that one cycle, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be N+1 cycles from the accepting edge to the cycle done is high; the next start is accepted in the cycle after done (throughput N+2 cycles).
REQ-020 start SHALL be ignored in ADD and DONE; a/b/cin changes after capture SHALL NOT affect the result.
REQ-021 sum/cout SHALL hold their last values until the next DONE; they SHALL NOT change during ADD.
REQ-022 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap during a valid operation; N=1 SHALL give one ADD cycle.
REQ-023 Arithmetic SHALL be unsigned modulo 2^N with cout as bit N; cout=1 exactly when A+B+cin >= 2^N.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, and clear shift and carry registers, regardless of clock.
REQ-025 Reset during ADD or DONE SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Configuration
REQ-026 When macro SERIAL_ADD_OVF_EN is defined, port ovf and a carry-into-MSB register SHALL exist; ovf SHALL be updated in DONE to (carry into bit N-1) XOR cout and held like sum.
REQ-027 When SERIAL_ADD_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 N=8, a=0xFF, b=0x01, cin=0, start pulse -> done high 9 cycles later, sum=0x00, cout=1.
REQ-029 N=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (with macro); a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-030 N=8, a=0x35, b=0x4A, cin=1, then start=1 with a=0xFF throughout ADD -> request ignored, sum=0x80, cout=0, exactly one done pulse.
REQ-031 rst asserted at the 4th ADD cycle -> busy=0, sum=0, no done; next start with a=0x10, b=0x20 -> sum=0x30 after 9 cycles.
REQ-032 Back-to-back: start held high continuously with a=0x01, b=0x01 -> done every 10 cycles, sum=0x02 each time.
REQ-033 N=1, a=1, b=1, cin=1 -> done 2 cycles after start, sum=1, cout=1.
